// File: rtl/cm_sketch_row_counter.sv
// Count-min sketch row: pipelined read-modify-write counter array with host read and clear sweep.
// Optional macro CM_ROW_SATURATE_EN makes increments saturate instead of wrapping.
module cm_sketch_row_counter #(
  parameter int W         = 4096,
  parameter int HASH_SIZE = $clog2(W),
  parameter int CNT_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [HASH_SIZE-1:0] in_hash,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [CNT_SIZE-1:0]  out_count,
  input  logic                 clear_req,
  output logic                 clear_done,
  output logic                 busy,
  input  logic                 rd_req,
  input  logic [HASH_SIZE-1:0] rd_idx,
  output logic                 rd_ack,
  output logic [CNT_SIZE-1:0]  rd_data
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_reg;
  logic [HASH_SIZE-1:0]  ptr_reg;
  logic                  clear_done_reg;

  logic                  m_upd_reg;
  logic                  m_rd_reg;
  logic [HASH_SIZE-1:0]  m_idx_reg;

  logic                  byp_valid_reg;
  logic [HASH_SIZE-1:0]  byp_idx_reg;
  logic [CNT_SIZE-1:0]   byp_data_reg;

  logic                  out_valid_reg;
  logic [CNT_SIZE-1:0]   out_count_reg;
  logic                  rd_ack_reg;
  logic [CNT_SIZE-1:0]   rd_data_reg;

  logic [CNT_SIZE-1:0]   mem [W];
  logic [CNT_SIZE-1:0]   ram_q;

  logic                  upd_accept;
  logic                  rd_issue;
  logic                  rd_en;
  logic [HASH_SIZE-1:0]  rd_addr;
  logic                  clear_wr;
  logic                  wr_en;
  logic [HASH_SIZE-1:0]  wr_addr;
  logic [CNT_SIZE-1:0]   wr_data;
  logic [CNT_SIZE-1:0]   sel;
  logic [CNT_SIZE-1:0]   inc_val;

  assign in_ready   = (state_reg == ST_RUN) && !clear_req;
  assign upd_accept = in_valid && in_ready;

  // Updates own the read port; a host read waits for an idle cycle and one outstanding at a time.
  assign rd_issue = rd_req && (state_reg == ST_RUN) && !upd_accept && !m_rd_reg && !rd_ack_reg;
  assign rd_en    = upd_accept || rd_issue;
  assign rd_addr  = upd_accept ? in_hash : rd_idx;

  // RAM returns old data on a same-cycle write, so the last write is forwarded here.
  assign sel = (byp_valid_reg && (byp_idx_reg == m_idx_reg)) ? byp_data_reg : ram_q;

`ifdef CM_ROW_SATURATE_EN
  assign inc_val = (&sel) ? sel : sel + CNT_SIZE'(1);
`else
  assign inc_val = sel + CNT_SIZE'(1);
`endif

  assign clear_wr = (state_reg == ST_CLEAR);
  assign wr_en    = clear_wr || m_upd_reg;
  assign wr_addr  = clear_wr ? ptr_reg : m_idx_reg;
  assign wr_data  = clear_wr ? '0 : inc_val;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_CLEAR;
      ptr_reg        <= '0;
      clear_done_reg <= 1'b0;
    end else begin
      clear_done_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (ptr_reg == HASH_SIZE'(W - 1)) begin
            state_reg      <= ST_RUN;
            ptr_reg        <= '0;
            clear_done_reg <= 1'b1;
          end else begin
            ptr_reg <= ptr_reg + HASH_SIZE'(1);
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_reg <= ST_CLEAR;
          ptr_reg   <= '0;
        end
        default: begin
          state_reg <= ST_CLEAR;
          ptr_reg   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_upd_reg     <= 1'b0;
      m_rd_reg      <= 1'b0;
      m_idx_reg     <= '0;
      byp_valid_reg <= 1'b0;
      byp_idx_reg   <= '0;
      byp_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_count_reg <= '0;
      rd_ack_reg    <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      m_upd_reg <= upd_accept;
      m_rd_reg  <= rd_issue;
      if (rd_en) begin
        m_idx_reg <= rd_addr;
      end

      if (clear_wr) begin
        byp_valid_reg <= 1'b0;
      end else if (m_upd_reg) begin
        byp_valid_reg <= 1'b1;
        byp_idx_reg   <= m_idx_reg;
        byp_data_reg  <= inc_val;
      end

      out_valid_reg <= m_upd_reg;
      if (m_upd_reg) begin
        out_count_reg <= inc_val;
      end

      rd_ack_reg <= m_rd_reg;
      if (m_rd_reg) begin
        rd_data_reg <= sel;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_count  = out_count_reg;
  assign clear_done = clear_done_reg;
  assign busy       = (state_reg != ST_RUN);
  assign rd_ack     = rd_ack_reg;
  assign rd_data    = rd_data_reg;

endmodule

// File: tb/tb_cm_sketch_row_counter.sv
// Bench for cm_sketch_row_counter (W=16, CNT_SIZE=4): array/queue model checked every cycle
// plus directed sequences with literal expectations.
module tb_cm_sketch_row_counter;
  localparam int W   = 16;
  localparam int HS  = 4;
  localparam int CW  = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [HS-1:0] in_hash = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          clear_req = 1'b0;
  logic          clear_done;
  logic          busy;
  logic          rd_req = 1'b0;
  logic [HS-1:0] rd_idx = '0;
  logic          rd_ack;
  logic [CW-1:0] rd_data;

  cm_sketch_row_counter #(.W(W), .HASH_SIZE(HS), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_hash(in_hash), .in_ready(in_ready),
    .out_valid(out_valid), .out_count(out_count),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int inc_m(int v);
`ifdef CM_ROW_SATURATE_EN
    return (v == MAXV) ? MAXV : v + 1;
`else
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  // Model: counts as plain ints, results queued with the cycle they must appear in.
  typedef struct {int due; int val;} ev_t;
  ev_t outq[$];
  ev_t rdq[$];
  int  mmem[W];
  int  mstate;     // 0 clearing, 1 running, 2 drain
  int  mptr;
  bit  done_flag;
  int  olog[$];
  int  rlog[$];
  int  last_ack_cyc = -1;

  always @(negedge clk) begin
    bit e_ir, e_ov, e_ra, accept, issue;
    int e_oc, e_rd;
    #1;
    if (!rst_n) begin
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_count", int'(out_count), 0);
      chk("reset in_ready", int'(in_ready), 0);
      chk("reset clear_done", int'(clear_done), 0);
      chk("reset rd_ack", int'(rd_ack), 0);
      chk("reset rd_data", int'(rd_data), 0);
      mstate = 0; mptr = 0; done_flag = 0;
      outq.delete(); rdq.delete();
      foreach (mmem[i]) mmem[i] = 0;
    end else begin
      e_ir = (mstate == 1) && !clear_req;
      e_ov = 0; e_oc = 0; e_ra = 0; e_rd = 0;
      if (outq.size() > 0 && outq[0].due == cyc) begin
        e_ov = 1; e_oc = outq[0].val; void'(outq.pop_front());
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        e_ra = 1; e_rd = rdq[0].val; void'(rdq.pop_front());
      end
      chk("in_ready", int'(in_ready), int'(e_ir));
      chk("busy", int'(busy), int'(mstate != 1));
      chk("clear_done", int'(clear_done), int'(done_flag));
      chk("out_valid", int'(out_valid), int'(e_ov));
      if (e_ov) chk("out_count", int'(out_count), e_oc);
      chk("rd_ack", int'(rd_ack), int'(e_ra));
      if (e_ra) chk("rd_data", int'(rd_data), e_rd);
      if (out_valid === 1'b1) olog.push_back(int'(out_count));
      if (rd_ack === 1'b1) begin
        rlog.push_back(int'(rd_data));
        last_ack_cyc = cyc;
      end

      accept = in_valid && e_ir;
      if (accept) begin
        mmem[in_hash] = inc_m(mmem[in_hash]);
        outq.push_back('{cyc + 2, mmem[in_hash]});
      end
      issue = rd_req && (mstate == 1) && !accept && (rdq.size() == 0) && !e_ra;
      if (issue) rdq.push_back('{cyc + 2, mmem[rd_idx]});

      done_flag = 0;
      case (mstate)
        0: begin
          mptr++;
          if (mptr == W) begin mstate = 1; done_flag = 1; end
        end
        1: if (clear_req) begin
          mstate = 2;
          foreach (mmem[i]) mmem[i] = 0;
        end
        default: begin mstate = 0; mptr = 0; end
      endcase
    end
    cyc++;
  end

  task automatic upd(input int idx);
    in_valid = 1'b1;
    in_hash = idx[HS-1:0];
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rd_host(input int idx, output int val);
    int n0;
    bit got;
    rd_req = 1'b1;
    rd_idx = idx[HS-1:0];
    n0 = rlog.size();
    got = 0;
    for (int k = 0; k < 30; k++) begin
      #2;
      if (rlog.size() > n0) begin got = 1; break; end
      @(negedge clk);
    end
    rd_req = 1'b0;
    chk("host read ack seen", int'(got), 1);
    val = got ? rlog[rlog.size() - 1] : -1;
    @(negedge clk);
  endtask

  // Counts cycles with in_ready low starting from the current one; requires clear_done on the rise.
  task automatic wait_ready(input string name, input int exp_n);
    int n;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      #2;
      if (in_ready === 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_n);
    chk({name, " clear_done"}, int'(clear_done), 1);
    @(negedge clk);
  endtask

  initial begin
    int v;
    int n;
    int drop_cyc;
    int n0;
    int exp3[5];
    exp3 = '{1, 2, 3, 1, 4};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init clear cycles", 16);
    for (int i = 0; i < W; i++) begin
      rd_host(i, v);
      chk("init read zero", v, 0);
    end

    olog.delete();
    upd(5);
    repeat (3) @(negedge clk);
    chk("single update count", (olog.size() > 0) ? olog[0] : -1, 1);
    rd_host(5, v);
    chk("read idx5", v, 1);

    olog.delete();
    upd(3); upd(3); upd(3); upd(7); upd(3);
    repeat (3) @(negedge clk);
    chk("b2b results", olog.size(), 5);
    for (int i = 0; i < 5; i++) chk("b2b count", (olog.size() > i) ? olog[i] : -1, exp3[i]);

    olog.delete();
    repeat (17) upd(9);
    repeat (3) @(negedge clk);
    chk("wrap results", olog.size(), 17);
`ifdef CM_ROW_SATURATE_EN
    chk("sat 15th", (olog.size() > 14) ? olog[14] : -1, 15);
    chk("sat 16th", (olog.size() > 15) ? olog[15] : -1, 15);
    chk("sat 17th", (olog.size() > 16) ? olog[16] : -1, 15);
`else
    chk("wrap 15th", (olog.size() > 14) ? olog[14] : -1, 15);
    chk("wrap 16th", (olog.size() > 15) ? olog[15] : -1, 0);
    chk("wrap 17th", (olog.size() > 16) ? olog[16] : -1, 1);
`endif

    olog.delete();
    upd(2);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    #2;
    chk("drain busy", int'(busy), 1);
    chk("pre-clear result", (olog.size() > 0) ? olog[0] : -1, 1);
    @(negedge clk);
    wait_ready("clear sweep cycles", 16);
    rd_host(2, v);
    chk("read idx2 after clear", v, 0);

    in_valid = 1'b1; in_hash = 4'd4;
    rd_req = 1'b1; rd_idx = 4'd4;
    n0 = rlog.size();
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    drop_cyc = cyc;
    chk("no ack under load", rlog.size(), n0);
    for (int k = 0; k < 10; k++) begin
      #2;
      if (rlog.size() > n0) break;
      @(negedge clk);
    end
    rd_req = 1'b0;
    chk("ack after load drops", last_ack_cyc - drop_cyc, 2);
    chk("read after 5 updates", (rlog.size() > n0) ? rlog[rlog.size() - 1] : -1, 5);
    @(negedge clk);

    upd(4);
    rd_host(4, v);
    chk("bypassed host read", v, 6);

    upd(1);
    in_valid = 1'b1; in_hash = 4'd1;
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reclear cycles", 16);
    rd_host(1, v);
    chk("read idx1 after reset", v, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
